// File: rtl/libhdl_sdr2ddr_ser_pkg.sv
// Shared types and helpers for the SDR-to-DDR output serializer slice.
// Bit-offset helpers map (lane, slot) to positions in the flat input beat.
package libhdl_sdr2ddr_ser_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ser_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  function automatic int rise_ofs(input int lane, input int slot, input int ratio);
    return lane * 2 * ratio + 2 * slot;
  endfunction

  function automatic int fall_ofs(input int lane, input int slot, input int ratio);
    return lane * 2 * ratio + 2 * slot + 1;
  endfunction

endpackage

// File: rtl/libhdl_ddr_oreg.sv
// Single-lane DDR output register: posedge rise/fall capture, negedge fall
// re-time, and the clock-steered output mux, all resetting to IDLE.
module libhdl_ddr_oreg
  import libhdl_sdr2ddr_ser_pkg::*;
#(
  parameter logic IDLE = 1'b0
) (
  input  logic ck,
  input  logic rstn,
  input  logic qr_d,
  input  logic qfp_d,
  output logic q
);

  logic qr;
  logic qfp;
  logic qf;

  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      qr  <= IDLE;
      qfp <= IDLE;
    end else begin
      qr  <= qr_d;
      qfp <= qfp_d;
    end
  end

  // Re-timing on the falling edge holds the fall bit for the full low phase.
  always_ff @(negedge ck or negedge rstn) begin
    if (!rstn) qf <= IDLE;
    else       qf <= qfp;
  end

  assign q = ck ? qr : qf;

endmodule

// File: rtl/libhdl_sdr2ddr_ser.sv
// N-lane SDR-to-DDR serializer: one beat of R rise/fall slot pairs per lane
// played out over R cycles. Optional training pattern under LIBHDL_SDR2DDR_TRAIN_EN.
module libhdl_sdr2ddr_ser
  import libhdl_sdr2ddr_ser_pkg::*;
#(
  parameter int   N    = 1,
  parameter int   R    = 2,
  parameter logic IDLE = 1'b0
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic [N*2*R-1:0] D,
  input  logic             DV,
  output logic             DR,
  output logic [N-1:0]     Q
`ifdef LIBHDL_SDR2DDR_TRAIN_EN
  ,
  input  logic             TRAIN
`endif
);

  localparam int CW = (R > 1) ? clog2(R) : 1;

  ser_state_t                st;
  logic [CW-1:0]             cnt;
  logic                      rdy_en;
  logic [N-1:0][R-1:0][1:0]  din;
  logic [N-1:0][R-1:0][1:0]  s;
  logic                      train;
  logic                      accept;
  logic                      last;
  logic [N-1:0]              qr_d;
  logic [N-1:0]              qfp_d;

`ifdef LIBHDL_SDR2DDR_TRAIN_EN
  assign train = TRAIN;
`else
  assign train = 1'b0;
`endif

  // The last slot clears busy as it is launched, so an idle state here already
  // means the next posedge is free: back-to-back beats leave no gap.
  assign DR     = rdy_en && (st == ST_IDLE) && !train;
  assign accept = DV && DR;
  assign last   = (cnt == CW'(R - 1));

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      rdy_en <= 1'b0;
      s      <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (train) begin
        st  <= ST_IDLE;
        cnt <= '0;
      end else if (accept) begin
        s <= din;
        if (R > 1) begin
          st  <= ST_BUSY;
          cnt <= CW'(1);
        end
      end else if (st == ST_BUSY) begin
        if (last) begin
          st  <= ST_IDLE;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  always_comb begin
    qr_d  = {N{IDLE}};
    qfp_d = {N{IDLE}};
    for (int k = 0; k < N; k++) begin
      if (train) begin
        qr_d[k]  = 1'b1;
        qfp_d[k] = 1'b0;
      end else if (accept) begin
        qr_d[k]  = din[k][0][0];
        qfp_d[k] = din[k][0][1];
      end else if (st == ST_BUSY) begin
        qr_d[k]  = s[k][cnt][0];
        qfp_d[k] = s[k][cnt][1];
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    for (genvar j = 0; j < R; j++) begin : g_slot
      assign din[k][j] = {D[fall_ofs(k, j, R)], D[rise_ofs(k, j, R)]};
    end

    libhdl_ddr_oreg #(
      .IDLE (IDLE)
    ) u_oreg (
      .ck    (CK),
      .rstn  (RSTN),
      .qr_d  (qr_d[k]),
      .qfp_d (qfp_d[k]),
      .q     (Q[k])
    );
  end

endmodule
